// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Width of the step counter: it must hold N-1, with at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the ALU controller and the divider.
interface div_if #(parameter int N = 4);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         neg_flag;
  logic         zr_flag;
  logic         cry_flag;
  logic         of_flag;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder,
    input  neg_flag, zr_flag, cry_flag, of_flag
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder,
    output neg_flag, zr_flag, cry_flag, of_flag
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, try the subtraction.
module div_step #(parameter int N = 4) (
  input  logic [N-1:0] rem,
  input  logic         din,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N:0] trial;
  logic [N:0] diff;

  // The trial value is N+1 bits so the shifted remainder never loses its top
  // bit; since rem < divisor, a non-negative difference always fits in N bits
  // and a negative one always sets bit N, so bit N is a clean borrow flag.
  always_comb begin
    trial    = {rem, din};
    diff     = trial - {1'b0, divisor};
    q_bit    = ~diff[N];
    rem_next = q_bit ? diff[N-1:0] : trial[N-1:0];
  end

endmodule

// File: rtl/div_module.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and the ALU neg/zr/cry/of flag set.
module div_module
  import div_pkg::*;
#(parameter int N = 4) (
  input logic clk,
  input logic rst_n,
  div_if.slave bus
);

  localparam int CW = cnt_width(N);

  div_state_t   state;
  logic [CW-1:0] count;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] rem;
  logic [N-1:0] rem_next;
  logic         q_bit;
  logic [N-1:0] q_final;

  div_step #(.N(N)) u_step (
    .rem      (rem),
    .din      (dividend[N-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Quotient bits shift into the vacated low end of the dividend register, so
  // after the last step this value is the complete quotient.
  assign q_final = {dividend[N-2:0], q_bit};

  // Control FSM plus working and result registers; results and flags only
  // change on the edge that enters DONE and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      dividend      <= '0;
      divisor       <= '0;
      rem           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.neg_flag  <= 1'b0;
      bus.zr_flag   <= 1'b0;
      bus.cry_flag  <= 1'b0;
      bus.of_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.b != '0) begin
              dividend <= bus.a;
              divisor  <= bus.b;
              rem      <= '0;
              count    <= CW'(N - 1);
              state    <= CALC;
            end else begin
              bus.quotient  <= '1;
              bus.remainder <= bus.a;
              bus.neg_flag  <= 1'b1;
              bus.zr_flag   <= 1'b0;
              bus.cry_flag  <= (bus.a != '0);
              bus.of_flag   <= 1'b1;
              bus.done      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        CALC: begin
          dividend <= q_final;
          rem      <= rem_next;
          count    <= count - 1'b1;
          if (count == '0) begin
            bus.quotient  <= q_final;
            bus.remainder <= rem_next;
            bus.neg_flag  <= q_final[N-1];
            bus.zr_flag   <= (q_final == '0);
            bus.cry_flag  <= (rem_next != '0);
            bus.of_flag   <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_module.sv
// Directed bench for div_module (N=4) with a result scoreboard.
module tb_div_module;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         neg;
    logic         zr;
    logic         cry;
    logic         of;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   pass_count;
  int   check_count;

  div_if #(.N(N)) bus();

  div_module #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a one-cycle start at the current negedge; optionally push the
  // expected result. Returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input bit keep);
    exp_t e;
    if (bv == 0) begin
      e.q   = '1;
      e.r   = av;
      e.of  = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = av / bv;
      e.r   = av % bv;
      e.of  = 1'b0;
      e.lat = N + 1;
    end
    e.neg = e.q[N-1];
    e.zr  = (e.q == 0);
    e.cry = (e.r != 0);
    if (keep) sb.push_back(e);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, then compare latency, results and flags with the
  // scoreboard head. Start is re-driven with a=1,b=1 in cycles 2..stray_until.
  task automatic waitAndCheck(input string tag, input int stray_until);
    exp_t e;
    int   cyc;
    e = sb.pop_front();
    cyc = 1;
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && cyc <= stray_until) begin
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    checkOutput({tag, " latency"}, 32'(cyc), 32'(e.lat));
    checkOutput({tag, " quotient"}, 32'(bus.quotient), 32'(e.q));
    checkOutput({tag, " remainder"}, 32'(bus.remainder), 32'(e.r));
    checkOutput({tag, " neg"}, 32'(bus.neg_flag), 32'(e.neg));
    checkOutput({tag, " zr"}, 32'(bus.zr_flag), 32'(e.zr));
    checkOutput({tag, " cry"}, 32'(bus.cry_flag), 32'(e.cry));
    checkOutput({tag, " of"}, 32'(bus.of_flag), 32'(e.of));
    checkOutput({tag, " busy at done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Every output must read zero.
  task automatic checkCleared(input string tag);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " quotient"}, 32'(bus.quotient), 32'd0);
    checkOutput({tag, " remainder"}, 32'(bus.remainder), 32'd0);
    checkOutput({tag, " flags"},
                32'({bus.neg_flag, bus.zr_flag, bus.cry_flag, bus.of_flag}), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    pass_count  = 0;
    check_count = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'd13, 4'd4, 1'b1);
    waitAndCheck("13/4", 0);
    applyStimulus(4'd12, 4'd3, 1'b1);
    waitAndCheck("12/3", 0);
    applyStimulus(4'd3, 4'd5, 1'b1);
    waitAndCheck("3/5", 0);
    applyStimulus(4'd15, 4'd1, 1'b1);
    waitAndCheck("15/1", 0);
    applyStimulus(4'd7, 4'd0, 1'b1);
    waitAndCheck("7/0", 0);

    applyStimulus(4'd9, 4'd2, 1'b1);
    waitAndCheck("9/2 stray", 4);
    repeat (3) @(negedge clk);
    checkOutput("hold quotient", 32'(bus.quotient), 32'd4);
    checkOutput("hold remainder", 32'(bus.remainder), 32'd1);
    checkOutput("hold busy", 32'(bus.busy), 32'd0);
    checkOutput("hold done", 32'(bus.done), 32'd0);

    applyStimulus(4'd14, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkCleared("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort no done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'd14, 4'd3, 1'b1);
    waitAndCheck("14/3", 0);

    checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
